// File: rtl/mp_cond_sub_pkg.sv
// Shared constants and FSM encoding for the multi-precision conditional subtractor.
// Imported by the interface, the datapath and the bench.
package mp_cond_sub_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_NSEG  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SEL  = 2'd2
  } state_e;

  // Segment index width, never narrower than one bit
  function automatic int idx_bits(input int nseg);
    if (nseg > 1) begin
      return $clog2(nseg);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mp_cond_sub_if.sv
// Operand/result bundle for mp_cond_sub; master issues requests, slave is the subtractor.
interface mp_cond_sub_if
  import mp_cond_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSEG  = DEF_NSEG
);

  localparam int N = WIDTH * NSEG;

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] m;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         borrow;

  modport master (
    output start, a, m,
    input  busy, done, result, borrow
  );

  modport slave (
    input  start, a, m,
    output busy, done, result, borrow
  );

endinterface

// File: rtl/mp_cond_sub_seg_adder.sv
// One-segment adder with carry in/out; the caller inverts the subtrahend to subtract.
module seg_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] total_s;

  assign total_s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign sum       = total_s[WIDTH-1:0];
  assign carry_out = total_s[WIDTH];

endmodule

// File: rtl/mp_cond_sub.sv
// Serial conditional subtraction result = (a >= m) ? a - m : a, one WIDTH-bit segment per clock.
// A final carry of 0 means a < m, in which case the latched minuend is returned unchanged.
module mp_cond_sub
  import mp_cond_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSEG  = DEF_NSEG
) (
  input  logic         clk,
  input  logic         reset,
  mp_cond_sub_if.slave bus
);

  localparam int            N        = WIDTH * NSEG;
  localparam int            IW       = idx_bits(NSEG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSEG - 1);

  state_e           state_r;
  state_e           state_s;
  logic             accept_s;
  logic             step_s;
  logic             sel_s;

  logic [N-1:0]     a_r;
  logic [N-1:0]     m_r;
  logic [N-1:0]     diff_r;
  logic [N-1:0]     result_r;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic             borrow_r;
  logic             done_r;
  logic             busy_r;

  logic [WIDTH-1:0] a_seg_s;
  logic [WIDTH-1:0] m_seg_s;
  logic [WIDTH-1:0] sum_s;
  logic             carry_out_s;

  // Next state and the per-cycle datapath enables
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    sel_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          state_s = ST_SEL;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SEL: begin
        sel_s   = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Segment selection from the latched operands, LSB segment at idx 0
  assign a_seg_s = a_r[int'(idx_r) * WIDTH +: WIDTH];
  assign m_seg_s = m_r[int'(idx_r) * WIDTH +: WIDTH];

  seg_adder #(
    .WIDTH (WIDTH)
  ) u_seg_adder (
    .a         (a_seg_s),
    .b         (~m_seg_s),
    .carry_in  (carry_r),
    .sum       (sum_s),
    .carry_out (carry_out_s)
  );

  // Operand latch, segment accumulation and final select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r      <= '0;
      m_r      <= '0;
      diff_r   <= '0;
      result_r <= '0;
      idx_r    <= '0;
      carry_r  <= 1'b1;
      borrow_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= sel_s;
      if (accept_s) begin
        a_r     <= bus.a;
        m_r     <= bus.m;
        idx_r   <= '0;
        carry_r <= 1'b1;
      end else if (step_s) begin
        diff_r[int'(idx_r) * WIDTH +: WIDTH] <= sum_s;
        carry_r <= carry_out_s;
        idx_r   <= (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
      end else if (sel_s) begin
        // Carry-out only flags the borrow; it never extends the result
        borrow_r <= ~carry_r;
        result_r <= carry_r ? diff_r : a_r;
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_mp_cond_sub.sv
// Self-checking bench: a WIDTH=8/NSEG=4 instance for directed corner cases and a
// default-parameter instance for randomized operands against an arithmetic reference.
module tb_mp_cond_sub;
  import mp_cond_sub_pkg::*;

  localparam int SW  = 8;
  localparam int SN  = 4;
  localparam int SNB = SW * SN;
  localparam int DN  = DEF_WIDTH * DEF_NSEG;

  logic clk = 1'b0;
  logic reset_sm;
  logic reset_df;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mp_cond_sub_if #(.WIDTH(SW), .NSEG(SN)) sm_if ();
  mp_cond_sub_if                          df_if ();

  mp_cond_sub #(.WIDTH(SW), .NSEG(SN)) dut_sm (
    .clk   (clk),
    .reset (reset_sm),
    .bus   (sm_if.slave)
  );

  mp_cond_sub dut_df (
    .clk   (clk),
    .reset (reset_df),
    .bus   (df_if.slave)
  );

  task automatic check_eq(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs[511:0], exp[511:0]);
    end
  endtask

  // Reference: plain comparison and subtraction on whole operands
  function automatic void ref_cond_sub(input logic [1023:0] av, input logic [1023:0] mv,
                                       output logic [1023:0] r, output logic b);
    if (av >= mv) begin
      r = av - mv;
      b = 1'b0;
    end else begin
      r = av;
      b = 1'b1;
    end
  endfunction

  function automatic logic [DN-1:0] rand_wide();
    logic [DN-1:0] v;
    for (int i = 0; i < DN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic op_sm(input string tag, input logic [SNB-1:0] av, input logic [SNB-1:0] mv);
    logic [1023:0] er;
    logic          eb;
    int            cyc;
    ref_cond_sub(1024'(av), 1024'(mv), er, eb);
    @(negedge clk);
    sm_if.start = 1'b1;
    sm_if.a     = av;
    sm_if.m     = mv;
    @(posedge clk);
    #1;
    sm_if.start = 1'b0;
    sm_if.a     = $urandom;
    sm_if.m     = $urandom;
    cyc = 0;
    while (sm_if.done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, " latency"}, 1024'(cyc), 1024'(SN + 1));
    check_eq({tag, " result"}, 1024'(sm_if.result), er);
    check_eq({tag, " borrow"}, 1024'(sm_if.borrow), 1024'(eb));
    @(posedge clk);
    #1;
    check_eq({tag, " done pulse"}, 1024'(sm_if.done), 1024'(0));
  endtask

  task automatic op_df(input string tag, input logic [DN-1:0] av, input logic [DN-1:0] mv);
    logic [1023:0] er;
    logic          eb;
    int            cyc;
    ref_cond_sub(1024'(av), 1024'(mv), er, eb);
    @(negedge clk);
    df_if.start = 1'b1;
    df_if.a     = av;
    df_if.m     = mv;
    @(posedge clk);
    #1;
    df_if.start = 1'b0;
    df_if.a     = rand_wide();
    df_if.m     = rand_wide();
    cyc = 0;
    while (df_if.done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, " latency"}, 1024'(cyc), 1024'(DEF_NSEG + 1));
    check_eq({tag, " result"}, 1024'(df_if.result), er);
    check_eq({tag, " borrow"}, 1024'(df_if.borrow), 1024'(eb));
    @(posedge clk);
    #1;
    check_eq({tag, " done pulse"}, 1024'(df_if.done), 1024'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SNB-1:0] sa, sm;
    logic [DN-1:0]  da, dm;
    logic           exp_done;

    reset_sm    = 1'b1;
    reset_df    = 1'b1;
    sm_if.start = 1'b0;
    sm_if.a     = '0;
    sm_if.m     = '0;
    df_if.start = 1'b0;
    df_if.a     = '0;
    df_if.m     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", 1024'(sm_if.busy), 1024'(0));
    check_eq("reset done", 1024'(sm_if.done), 1024'(0));
    check_eq("reset borrow", 1024'(sm_if.borrow), 1024'(0));
    check_eq("reset result", 1024'(sm_if.result), 1024'(0));
    check_eq("reset df busy", 1024'(df_if.busy), 1024'(0));
    check_eq("reset df result", 1024'(df_if.result), 1024'(0));
    @(negedge clk);
    reset_sm = 1'b0;
    reset_df = 1'b0;

    op_sm("a105_m100", 32'h0000_0105, 32'h0000_0100);
    op_sm("aFF_m100", 32'h0000_00FF, 32'h0000_0100);
    op_sm("a_eq_m", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    op_sm("m_zero", 32'hFFFF_FFFF, 32'h0000_0000);
    op_sm("a_m_minus1", 32'h1234_5677, 32'h1234_5678);

    // start held high: one done per accepted start, next start taken on the done cycle
    @(negedge clk);
    sm_if.a     = 32'h1234_5678;
    sm_if.m     = 32'h0123_4567;
    sm_if.start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk);
      #1;
      exp_done = ((c % 6) == 5);
      check_eq($sformatf("hold done c%0d", c), 1024'(sm_if.done), 1024'(exp_done));
      check_eq($sformatf("hold busy c%0d", c), 1024'(sm_if.busy), 1024'(!exp_done));
    end
    sm_if.start = 1'b0;
    check_eq("hold result", 1024'(sm_if.result), 1024'(32'h1111_1111));
    @(posedge clk);
    #1;

    // asynchronous reset while idx = 2
    @(negedge clk);
    sm_if.start = 1'b1;
    sm_if.a     = 32'h0000_0300;
    sm_if.m     = 32'h0000_0100;
    @(posedge clk);
    #1;
    sm_if.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("pre-reset busy", 1024'(sm_if.busy), 1024'(1));
    reset_sm = 1'b1;
    #1;
    check_eq("mid reset busy", 1024'(sm_if.busy), 1024'(0));
    check_eq("mid reset done", 1024'(sm_if.done), 1024'(0));
    check_eq("mid reset borrow", 1024'(sm_if.borrow), 1024'(0));
    check_eq("mid reset result", 1024'(sm_if.result), 1024'(0));
    @(negedge clk);
    reset_sm = 1'b0;
    op_sm("post_reset", 32'h0000_0300, 32'h0000_0100);

    for (int i = 0; i < 200; i++) begin
      sa = $urandom;
      case ($urandom_range(0, 4))
        0:       sm = sa;
        1:       sm = sa + 32'd1;
        2:       sm = 32'd0;
        3:       sm = sa ^ (32'd1 << $urandom_range(0, 31));
        default: sm = $urandom;
      endcase
      op_sm($sformatf("sm_rand%0d", i), sa, sm);
    end

    for (int i = 0; i < 1500; i++) begin
      da = rand_wide();
      case ($urandom_range(0, 4))
        0:       dm = da;
        1:       dm = da + DN'(1);
        2:       dm = '0;
        3:       dm = da ^ (DN'(1) << $urandom_range(0, DN - 1));
        default: dm = rand_wide();
      endcase
      op_df($sformatf("df_rand%0d", i), da, dm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
